credit_rr_arbiter: RTL and testbench

- Parametrised N-input round-robin arbiter with wormhole packet locking and a downstream credit counter, for one router output port.
- Receives per-input requests and tail markers, grants one input at a time and holds the grant until that packet's tail flit has transferred.
- Allows a flit transfer only while downstream credits are available.
- Successor to the single-credit arbiter: generalises input count and credit depth, and adds fairness, packet locking and credit accounting.

---
 rtl/credit_rr_arbiter.sv | 74 +++++++
 tb/tb_credit_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_arbiter.sv
// credit_rr_arbiter: round-robin wormhole arbiter with a downstream credit counter (CREDIT_RR_ARBITER_CREDIT_CHECK_EN adds sticky credit_err_out)
module credit_rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int CREDIT_DEPTH = 4,
  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] request_in,
  input  logic [NUM_REQ-1:0] tail_in,
  input  logic               credit_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic               grant_valid_out,
  output logic               transfer_out,
`ifdef CREDIT_RR_ARBITER_CREDIT_CHECK_EN
  output logic [CNT_W-1:0]   credits_out,
  output logic               credit_err_out
`else
  output logic [CNT_W-1:0]   credits_out
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [PW-1:0] ptr, gidx, win;
  logic tail_xfer, full;
  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v >= NUM_REQ ? v - NUM_REQ : v);
  endfunction
  assign full = credits_out == CNT_W'(CREDIT_DEPTH);
  assign transfer_out = grant_valid_out & |(request_in & grant_out) & (credits_out != '0);
  assign tail_xfer = transfer_out & |(tail_in & grant_out);
  // downward scan so the last hit is the first requester at or above the pointer
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (request_in[wrap_idx(int'(ptr) + i)]) win = wrap_idx(int'(ptr) + i);
  end
  // grant FSM: lock onto a winner until its tail flit moves, then advance the pointer past it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant_out <= '0;
      grant_valid_out <= 1'b0;
      ptr <= '0;
      gidx <= '0;
    end else if (state == IDLE) begin
      if (|request_in) begin
        state <= LOCKED;
        grant_out <= NUM_REQ'(1) << win;
        grant_valid_out <= 1'b1;
        gidx <= win;
      end
    end else if (tail_xfer) begin
      state <= IDLE;
      grant_out <= '0;
      grant_valid_out <= 1'b0;
      ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
  // credit counter: transfers consume, credit pulses return, saturating at full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credits_out <= CNT_W'(CREDIT_DEPTH);
    else if (transfer_out && !credit_in) credits_out <= credits_out - 1'b1;
    else if (credit_in && !transfer_out && !full) credits_out <= credits_out + 1'b1;
  end
`ifdef CREDIT_RR_ARBITER_CREDIT_CHECK_EN
  // sticky flag for a credit returned while the counter is already full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credit_err_out <= 1'b0;
    else if (credit_in && full) credit_err_out <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_credit_rr_arbiter.sv
// tb_credit_rr_arbiter: scoreboard bench for credit_rr_arbiter
module tb_credit_rr_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] request_in, tail_in, grant_out;
  logic credit_in, grant_valid_out, transfer_out;
  logic [2:0] credits_out;
`ifdef CREDIT_RR_ARBITER_CREDIT_CHECK_EN
  logic credit_err_out;
`endif
  int checks = 0;
  int errors = 0;
  int exp_g[$];
  typedef struct {int g; int c;} xfer_t;
  xfer_t exp_x[$];
  logic prev_gv = 1'b0;
  int ord[7] = '{0, 1, 2, 3, 4, 0, 1};

  credit_rr_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .request_in(request_in),
    .tail_in(tail_in),
    .credit_in(credit_in),
    .grant_out(grant_out),
    .grant_valid_out(grant_valid_out),
    .transfer_out(transfer_out),
`ifdef CREDIT_RR_ARBITER_CREDIT_CHECK_EN
    .credits_out(credits_out),
    .credit_err_out(credit_err_out)
`else
    .credits_out(credits_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic c);
    @(posedge clk);
    #1;
    request_in = r;
    tail_in = t;
    credit_in = c;
    #1;
  endtask

  task automatic px(input int g, input int c);
    xfer_t x;
    x.g = g;
    x.c = c;
    exp_x.push_back(x);
  endtask

  // monitor: new grants and every flit transfer are popped from the scoreboard queues
  always @(negedge clk) begin
    if (grant_valid_out && !prev_gv) begin
      if (exp_g.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant got %b", grant_out);
      end else chk("grant", grant_out, exp_g.pop_front());
    end
    prev_gv = grant_valid_out;
    if (transfer_out) begin
      if (exp_x.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer grant %b credits %0d", grant_out, credits_out);
      end else begin
        xfer_t x;
        x = exp_x.pop_front();
        chk("xfer_grant", grant_out, x.g);
        chk("xfer_credits", credits_out, x.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    request_in = '0;
    tail_in = '0;
    credit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_grant", grant_out, 0);
    chk("rst_gv", grant_valid_out, 0);
    chk("rst_credits", credits_out, 4);
    chk("rst_transfer", transfer_out, 0);
    // inputs 0 and 2 request; input 0 sends three flits
    exp_g.push_back(5'b00001);
    cyc(5'b00101, 5'b00000, 0);
    cyc(5'b00101, 5'b00000, 0); px(1, 4);
    cyc(5'b00101, 5'b00000, 0); px(1, 3);
    cyc(5'b00101, 5'b00001, 0); px(1, 2);
    exp_g.push_back(5'b00100);
    cyc(5'b00100, 5'b00000, 0);
    chk("bubble_grant", grant_out, 0);
    chk("bubble_gv", grant_valid_out, 0);
    cyc(5'b00100, 5'b00100, 0); px(4, 1);
    repeat (4) cyc(5'b00000, 5'b00000, 1);
    // input 1 six-flit packet against four credits
    exp_g.push_back(5'b00010);
    cyc(5'b00010, 5'b00000, 0);
    chk("refill_credits", credits_out, 4);
    for (int k = 4; k >= 1; k--) begin
      cyc(5'b00010, 5'b00000, 0);
      px(2, k);
    end
    repeat (2) begin
      cyc(5'b00010, 5'b00000, 0);
      chk("stall_transfer", transfer_out, 0);
      chk("stall_credits", credits_out, 0);
    end
    cyc(5'b00010, 5'b00000, 1);
    chk("credit_arrive_transfer", transfer_out, 0);
    cyc(5'b00010, 5'b00000, 0); px(2, 1);
    chk("one_credit", credits_out, 1);
    cyc(5'b00000, 5'b00000, 1);
    chk("after_one_credits", credits_out, 0);
    chk("req_low_transfer", transfer_out, 0);
    cyc(5'b00000, 5'b00000, 1);
    cyc(5'b00010, 5'b00010, 1); px(2, 2);
    chk("simul_pre", credits_out, 2);
    cyc(5'b00000, 5'b00000, 1);
    chk("simul_post", credits_out, 2);
    chk("tail_release_gv", grant_valid_out, 0);
    cyc(5'b00000, 5'b00000, 1);
    cyc(5'b00000, 5'b00000, 0);
    chk("refill2_credits", credits_out, 4);
    // pointer now 2: input 3 wins, then reset mid-packet
    exp_g.push_back(5'b01000);
    cyc(5'b01001, 5'b00000, 0);
    cyc(5'b01001, 5'b00000, 0); px(8, 4);
    @(negedge clk);
    #1 reset_n = 1'b0;
    request_in = '0;
    #1;
    chk("midrst_grant", grant_out, 0);
    chk("midrst_credits", credits_out, 4);
    @(posedge clk);
    #1 reset_n = 1'b1;
    // fairness with single-flit packets from all inputs
    for (int k = 0; k < 14; k++) begin
      if (k % 2 == 0 && k < 13) exp_g.push_back(1 << ord[k / 2]);
      cyc(5'b11111, 5'b11111, k % 2 == 1);
      if (k % 2 == 1) px(1 << ord[k / 2], 4);
      else chk("fair_bubble", grant_valid_out, 0);
    end
    cyc(5'b00000, 5'b00000, 0);
    chk("fair_end_gv", grant_valid_out, 0);
    chk("fair_end_credits", credits_out, 4);
    // credit return while already full
    cyc(5'b00000, 5'b00000, 1);
    cyc(5'b00000, 5'b00000, 0);
    chk("ovf_credits", credits_out, 4);
`ifdef CREDIT_RR_ARBITER_CREDIT_CHECK_EN
    chk("ovf_err", credit_err_out, 1);
    repeat (3) cyc(5'b00000, 5'b00000, 0);
    chk("ovf_err_sticky", credit_err_out, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("ovf_err_reset", credit_err_out, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
`endif
    @(posedge clk);
    #1;
    chk("grant_queue_empty", exp_g.size(), 0);
    chk("xfer_queue_empty", exp_x.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
